pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline hazard and sequencing controller for the milano core. It sits beside the IF, ID and EX stages. It drives the stall and flush inputs of the IF/ID and ID/EX pipeline registers, the ID stage's stall and refresh controls included. It resolves load-use hazards, holds the pipe during multi-cycle mul/div and LSU accesses, redirects the PC on taken jumps, and sequences ecall/ebreak trap entry, including the mepc/mcause writes.

## Interface
Parameters:
- TRAP_VEC_ALIGN, 2: number of low bits of mtvec_i forced to zero when forming the trap target.
- STALL_CNT_W, 16: width of the saturating stall-cycle counter.

Ports:
- clk_i  in  1  single clock, rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- id_rs1_addr_i / id_rs2_addr_i  in  5  source registers of the instruction in ID.
- id_rs1_used_i / id_rs2_used_i  in  1  the ID instruction reads rs1 / rs2.
- ex_rd_addr_i  in  5  destination register of the instruction in EX.
- ex_rd_wr_en_i  in  1  the EX instruction writes rd.
- ex_lsu_req_i / ex_lsu_we_i  in  1  the EX instruction is a memory access / a store.
- lsu_done_i  in  1  the LSU finished the current access this cycle.
- ex_md_sel_i  in  1  the EX instruction is a mul/div.
- md_done_i  in  1  the mul/div result is valid this cycle.
- ex_jump_flag_i  in  1  the EX instruction is a taken jump or branch.
- ex_jump_addr_i  in  32  jump target.
- ex_ecall_i / ex_ebreak_i  in  1  trap flags of the EX instruction.
- ex_pc_i  in  32  PC of the EX instruction.
- mtvec_i  in  32  trap vector base from the CSR file.
- stall_if_o  out  1  hold the PC and the IF/ID register.
- stall_id_o  out  1  hold the ID/EX register (feeds stall_from_ctrl_i).
- flush_if_o  out  1  clear the IF/ID register to a NOP.
- flush_id_o  out  1  clear the ID/EX register to a bubble (feeds refresh_pip_i).
- pc_redirect_o  out  1  load the PC from pc_target_o.
- pc_target_o  out  32  redirect target.
- trap_we_o  out  1  write mepc and mcause this cycle.
- trap_mepc_o  out  32  mepc value.
- trap_mcause_o  out  32  mcause value.
- stall_cnt_o  out  STALL_CNT_W  saturating count of cycles with stall_if_o=1.

## Operation
- FSM states: RUN, MD_WAIT, LSU_WAIT, TRAP. The reset state is RUN.
- Event priority within RUN, highest first: trap, jump, mul/div, LSU, load-use.
- **Trap:** raised by ex_ecall_i or ex_ebreak_i in RUN.
  - In the same cycle: trap_we_o=1, trap_mepc_o=ex_pc_i, trap_mcause_o=11 for ecall or 3 for ebreak. If both flags are set, ecall wins.
  - Also in the same cycle: flush_if_o=1 and flush_id_o=1.
  - Next state is TRAP.
- **TRAP state (1 cycle):**
  - pc_redirect_o=1.
  - pc_target_o = mtvec_i with the low TRAP_VEC_ALIGN bits cleared.
  - flush_if_o=1, flush_id_o=1.
  - Next state is RUN.
- **Jump:** ex_jump_flag_i in RUN with no trap gives, combinationally:
  - pc_redirect_o=1 and pc_target_o=ex_jump_addr_i.
  - flush_if_o=1 and flush_id_o=1.
  - The state stays RUN.
- **Mul/div:** ex_md_sel_i in RUN with md_done_i=0 gives:
  - stall_if_o=1 and stall_id_o=1.
  - Next state is MD_WAIT.
  - In MD_WAIT the stalls are held until md_done_i=1. In that cycle the stalls drop and the next state is RUN.
  - If md_done_i=1 in the issue cycle, there is no stall.
- **LSU:** same pattern as mul/div, using ex_lsu_req_i, lsu_done_i and the LSU_WAIT state.
- **Load-use:** all of the following must hold:
  - ex_lsu_req_i=1, ex_lsu_we_i=0, ex_rd_wr_en_i=1, ex_rd_addr_i≠0.
  - ex_rd_addr_i matches a used ID source register.

  When they hold: stall_if_o=1, flush_id_o=1 (a bubble enters EX) and stall_id_o=0. This lasts one cycle per occurrence. The load-use check is evaluated only when no higher-priority event is active.
- **Trap and jump sampling:** trap and jump inputs are ignored outside RUN. Upstream holds them stable during stalls, and they are evaluated on return to RUN.
- **stall_cnt_o:** increments by 1 each cycle stall_if_o=1. It saturates at all-ones and cannot wrap.
- Outputs outside these cases are 0; pc_target_o, trap_mepc_o and trap_mcause_o are then 0.

## Timing
- **Reset:** rst_i sampled high gives state RUN, stall_cnt_o=0, and all combinational outputs 0 while rst_i=1. This applies in any state, including mid-MD_WAIT and mid-TRAP; a trap in progress is abandoned with no redirect.
- **Latency:** all control outputs are combinational from the inputs and the current state, in the same cycle. The only registered elements are the state register and stall_cnt_o.
- **Cycle cost:**
  - Trap entry takes exactly 2 cycles: the mepc-write cycle, then the redirect cycle.
  - A jump costs 1 cycle.
  - A load-use hazard costs 1 bubble.
  - A mul/div or LSU access that completes N cycles after issue costs N stall cycles.
- **Done in the wait state:** md_done_i / lsu_done_i in the cycle of leaving the wait state means the stalls are already low in that cycle.
- **Output combinations:** stall_id_o=1 always implies stall_if_o=1. flush_id_o and stall_id_o are never both 1.

## Test plan
- **Load-use:** EX holds lw with rd=x5; ID holds add with rs1=x5 -> one cycle of stall_if_o=1, flush_id_o=1, stall_id_o=0. Repeat with rd=x0 -> no stall.
- **Mul/div:** div issued; md_done_i rises 5 cycles later -> stall_if_o=stall_id_o=1 for 5 cycles, stall_cnt_o+=5, state back to RUN.
- **Jump:** ex_jump_flag_i=1, ex_jump_addr_i=0x0000_0100 -> pc_redirect_o=1, pc_target_o=0x100, flush_if_o=flush_id_o=1 for one cycle.
- **ecall:** ex_ecall_i at ex_pc_i=0x80 with mtvec_i=0x203 ->
  - cycle 0: trap_we_o=1, trap_mepc_o=0x80, trap_mcause_o=11.
  - cycle 1: pc_redirect_o=1, pc_target_o=0x200.
- **Simultaneous events:** ecall, ebreak and jump asserted together -> the trap path only, mcause=11, no jump redirect.
- **Reset and saturation:**
  - rst_i during MD_WAIT -> next cycle state RUN, all outputs 0, stall_cnt_o=0.
  - Force 2^STALL_CNT_W+3 stall cycles -> stall_cnt_o holds 0xFFFF.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// Signal bundle between the hazard/sequencing controller and the IF/ID/EX stages.
// master = controller side, slave = pipeline side.
interface pipe_ctrl_if #(
    parameter int STALL_CNT_W = 16
);
    logic [4:0]             id_rs1_addr_i;
    logic [4:0]             id_rs2_addr_i;
    logic                   id_rs1_used_i;
    logic                   id_rs2_used_i;
    logic [4:0]             ex_rd_addr_i;
    logic                   ex_rd_wr_en_i;
    logic                   ex_lsu_req_i;
    logic                   ex_lsu_we_i;
    logic                   lsu_done_i;
    logic                   ex_md_sel_i;
    logic                   md_done_i;
    logic                   ex_jump_flag_i;
    logic [31:0]            ex_jump_addr_i;
    logic                   ex_ecall_i;
    logic                   ex_ebreak_i;
    logic [31:0]            ex_pc_i;
    logic [31:0]            mtvec_i;

    logic                   stall_if_o;
    logic                   stall_id_o;
    logic                   flush_if_o;
    logic                   flush_id_o;
    logic                   pc_redirect_o;
    logic [31:0]            pc_target_o;
    logic                   trap_we_o;
    logic [31:0]            trap_mepc_o;
    logic [31:0]            trap_mcause_o;
    logic [STALL_CNT_W-1:0] stall_cnt_o;
    logic [1:0]             state_dbg_o;

    // Control semantics: every output is a same-cycle level. stall_* holds a
    // register for this cycle, flush_* loads it with a NOP/bubble this cycle,
    // pc_redirect_o loads the PC from pc_target_o at the next rising edge.
    modport master (
        input  id_rs1_addr_i, id_rs2_addr_i, id_rs1_used_i, id_rs2_used_i,
        input  ex_rd_addr_i, ex_rd_wr_en_i, ex_lsu_req_i, ex_lsu_we_i, lsu_done_i,
        input  ex_md_sel_i, md_done_i, ex_jump_flag_i, ex_jump_addr_i,
        input  ex_ecall_i, ex_ebreak_i, ex_pc_i, mtvec_i,
        output stall_if_o, stall_id_o, flush_if_o, flush_id_o,
        output pc_redirect_o, pc_target_o, trap_we_o, trap_mepc_o, trap_mcause_o,
        output stall_cnt_o, state_dbg_o
    );

    modport slave (
        output id_rs1_addr_i, id_rs2_addr_i, id_rs1_used_i, id_rs2_used_i,
        output ex_rd_addr_i, ex_rd_wr_en_i, ex_lsu_req_i, ex_lsu_we_i, lsu_done_i,
        output ex_md_sel_i, md_done_i, ex_jump_flag_i, ex_jump_addr_i,
        output ex_ecall_i, ex_ebreak_i, ex_pc_i, mtvec_i,
        input  stall_if_o, stall_id_o, flush_if_o, flush_id_o,
        input  pc_redirect_o, pc_target_o, trap_we_o, trap_mepc_o, trap_mcause_o,
        input  stall_cnt_o, state_dbg_o
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline hazard and sequencing controller for the milano core: load-use bubbles,
// mul/div and LSU wait stalls, jump redirects and two-cycle ecall/ebreak trap entry.
module pipe_ctrl #(
    parameter int TRAP_VEC_ALIGN = 2,
    parameter int STALL_CNT_W    = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    pipe_ctrl_if.master bus
);
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MD_WAIT  = 2'd1,
        LSU_WAIT = 2'd2,
        TRAP     = 2'd3
    } state_t;

    localparam logic [31:0] VEC_MASK = ~((32'd1 << TRAP_VEC_ALIGN) - 32'd1);

    state_t                 state_q, state_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q;

    logic        stall_if, stall_id, flush_if, flush_id, pc_redirect, trap_we;
    logic [31:0] pc_target, trap_mepc, trap_mcause;
    logic        rs_match, load_use;

    assign rs_match = (bus.id_rs1_used_i && (bus.id_rs1_addr_i == bus.ex_rd_addr_i)) ||
                      (bus.id_rs2_used_i && (bus.id_rs2_addr_i == bus.ex_rd_addr_i));
    assign load_use = bus.ex_lsu_req_i && !bus.ex_lsu_we_i && bus.ex_rd_wr_en_i &&
                      (bus.ex_rd_addr_i != 5'd0) && rs_match;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= RUN;
            stall_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (stall_if && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        stall_if    = 1'b0;
        stall_id    = 1'b0;
        flush_if    = 1'b0;
        flush_id    = 1'b0;
        pc_redirect = 1'b0;
        pc_target   = 32'd0;
        trap_we     = 1'b0;
        trap_mepc   = 32'd0;
        trap_mcause = 32'd0;

        // Reset silences every output, abandoning any trap still in flight.
        if (rst_i) begin
            state_d = RUN;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (bus.ex_ecall_i || bus.ex_ebreak_i) begin
                        trap_we     = 1'b1;
                        trap_mepc   = bus.ex_pc_i;
                        trap_mcause = bus.ex_ecall_i ? 32'd11 : 32'd3;
                        flush_if    = 1'b1;
                        flush_id    = 1'b1;
                        state_d     = TRAP;
                    end else if (bus.ex_jump_flag_i) begin
                        pc_redirect = 1'b1;
                        pc_target   = bus.ex_jump_addr_i;
                        flush_if    = 1'b1;
                        flush_id    = 1'b1;
                    end else if (bus.ex_md_sel_i && !bus.md_done_i) begin
                        stall_if = 1'b1;
                        stall_id = 1'b1;
                        state_d  = MD_WAIT;
                    end else if (bus.ex_lsu_req_i && !bus.lsu_done_i) begin
                        stall_if = 1'b1;
                        stall_id = 1'b1;
                        state_d  = LSU_WAIT;
                    end else if (load_use) begin
                        // Hold IF/ID, let the load advance and inject a bubble behind it.
                        stall_if = 1'b1;
                        flush_id = 1'b1;
                    end
                end
                MD_WAIT: begin
                    if (bus.md_done_i) begin
                        state_d = RUN;
                    end else begin
                        stall_if = 1'b1;
                        stall_id = 1'b1;
                    end
                end
                LSU_WAIT: begin
                    if (bus.lsu_done_i) begin
                        state_d = RUN;
                    end else begin
                        stall_if = 1'b1;
                        stall_id = 1'b1;
                    end
                end
                TRAP: begin
                    pc_redirect = 1'b1;
                    pc_target   = bus.mtvec_i & VEC_MASK;
                    flush_if    = 1'b1;
                    flush_id    = 1'b1;
                    state_d     = RUN;
                end
                default: state_d = RUN;
            endcase
        end
    end

    assign bus.stall_if_o    = stall_if;
    assign bus.stall_id_o    = stall_id;
    assign bus.flush_if_o    = flush_if;
    assign bus.flush_id_o    = flush_id;
    assign bus.pc_redirect_o = pc_redirect;
    assign bus.pc_target_o   = pc_target;
    assign bus.trap_we_o     = trap_we;
    assign bus.trap_mepc_o   = trap_mepc;
    assign bus.trap_mcause_o = trap_mcause;
    assign bus.stall_cnt_o   = stall_cnt_q;
    assign bus.state_dbg_o   = state_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: per-scenario tasks push expected output
// vectors into a queue and pop/compare them at the falling edge.
module tb_pipe_ctrl;
    localparam int CW = 16;
    localparam int VW = 6 + 96 + CW + 2;

    localparam logic [5:0] F_NONE  = 6'b000000;
    localparam logic [5:0] F_STALL = 6'b110000;
    localparam logic [5:0] F_LU    = 6'b100100;
    localparam logic [5:0] F_JMP   = 6'b001110;
    localparam logic [5:0] F_TRAPW = 6'b001101;

    localparam logic [1:0] S_RUN = 2'd0;
    localparam logic [1:0] S_MD  = 2'd1;
    localparam logic [1:0] S_LSU = 2'd2;
    localparam logic [1:0] S_TRP = 2'd3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_ctrl_if #(.STALL_CNT_W(CW)) bus ();

    pipe_ctrl #(.TRAP_VEC_ALIGN(2), .STALL_CNT_W(CW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    logic [VW-1:0] exp_q[$];
    logic [CW-1:0] exp_cnt = '0;
    int            n_tests = 0;
    int            n_fail  = 0;

    function automatic logic [VW-1:0] obs();
        return {bus.stall_if_o, bus.stall_id_o, bus.flush_if_o, bus.flush_id_o,
                bus.pc_redirect_o, bus.trap_we_o, bus.pc_target_o, bus.trap_mepc_o,
                bus.trap_mcause_o, bus.stall_cnt_o, bus.state_dbg_o};
    endfunction

    function automatic logic [VW-1:0] mk_exp(input logic [5:0] f, input logic [31:0] tgt,
                                             input logic [31:0] mepc, input logic [31:0] mcause,
                                             input logic [1:0] st);
        return {f, tgt, mepc, mcause, exp_cnt, st};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        rst                = 1'b0;
        bus.id_rs1_addr_i  = 5'd0;
        bus.id_rs2_addr_i  = 5'd0;
        bus.id_rs1_used_i  = 1'b0;
        bus.id_rs2_used_i  = 1'b0;
        bus.ex_rd_addr_i   = 5'd0;
        bus.ex_rd_wr_en_i  = 1'b0;
        bus.ex_lsu_req_i   = 1'b0;
        bus.ex_lsu_we_i    = 1'b0;
        bus.lsu_done_i     = 1'b0;
        bus.ex_md_sel_i    = 1'b0;
        bus.md_done_i      = 1'b0;
        bus.ex_jump_flag_i = 1'b0;
        bus.ex_jump_addr_i = 32'd0;
        bus.ex_ecall_i     = 1'b0;
        bus.ex_ebreak_i    = 1'b0;
        bus.ex_pc_i        = 32'd0;
        bus.mtvec_i        = 32'h203;
    endtask

    task automatic set_load(input logic [4:0] rd);
        bus.ex_lsu_req_i  = 1'b1;
        bus.ex_lsu_we_i   = 1'b0;
        bus.ex_rd_wr_en_i = 1'b1;
        bus.ex_rd_addr_i  = rd;
        bus.lsu_done_i    = 1'b1;
    endtask

    // Push the expected vector, advance the stall-count model, wait for the sample point.
    task automatic drive(input logic [VW-1:0] e);
        exp_q.push_back(e);
        if (e[VW-1] && (exp_cnt != '1)) exp_cnt = exp_cnt + 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [VW-1:0] got, e;
        for (int c = 0; c < 2; c++) begin
            if (c == 0) begin
                set_idle();
                rst = 1'b1;
                bus.ex_jump_flag_i = 1'b1;
                bus.ex_md_sel_i    = 1'b1;
                next_cycle();
            end else begin
                next_cycle();
            end
            drive(mk_exp(F_NONE, 32'd0, 32'd0, 32'd0, S_RUN));
            got = obs(); e = exp_q.pop_front(); n_tests++;
            if (got !== e) begin n_fail++; $display("FAIL reset c%0d got=%h exp=%h", c, got, e); end
        end
    endtask

    task automatic test_load_use();
        logic [VW-1:0] got, e;
        for (int c = 0; c < 6; c++) begin
            next_cycle(); set_idle();
            case (c)
                0: begin
                    set_load(5'd5); bus.id_rs1_addr_i = 5'd5; bus.id_rs1_used_i = 1'b1;
                    drive(mk_exp(F_LU, 32'd0, 32'd0, 32'd0, S_RUN));
                end
                2: begin
                    set_load(5'd0); bus.id_rs1_addr_i = 5'd0; bus.id_rs1_used_i = 1'b1;
                    drive(mk_exp(F_NONE, 32'd0, 32'd0, 32'd0, S_RUN));
                end
                3: begin
                    set_load(5'd7); bus.id_rs1_addr_i = 5'd5; bus.id_rs1_used_i = 1'b1;
                    bus.id_rs2_addr_i = 5'd7; bus.id_rs2_used_i = 1'b1;
                    drive(mk_exp(F_LU, 32'd0, 32'd0, 32'd0, S_RUN));
                end
                4: begin
                    set_load(5'd7); bus.id_rs2_addr_i = 5'd7; bus.id_rs2_used_i = 1'b0;
                    drive(mk_exp(F_NONE, 32'd0, 32'd0, 32'd0, S_RUN));
                end
                5: begin
                    set_load(5'd9); bus.ex_lsu_we_i = 1'b1;
                    bus.id_rs1_addr_i = 5'd9; bus.id_rs1_used_i = 1'b1;
                    drive(mk_exp(F_NONE, 32'd0, 32'd0, 32'd0, S_RUN));
                end
                default: drive(mk_exp(F_NONE, 32'd0, 32'd0, 32'd0, S_RUN));
            endcase
            got = obs(); e = exp_q.pop_front(); n_tests++;
            if (got !== e) begin n_fail++; $display("FAIL load_use c%0d got=%h exp=%h", c, got, e); end
        end
    endtask

    task automatic test_muldiv();
        logic [VW-1:0] got, e;
        for (int c = 0; c < 9; c++) begin
            next_cycle(); set_idle();
            if (c <= 5) bus.ex_md_sel_i = 1'b1;
            if (c == 7) begin bus.ex_md_sel_i = 1'b1; bus.md_done_i = 1'b1; end
            if (c == 5) bus.md_done_i = 1'b1;
            case (c)
                0:          drive(mk_exp(F_STALL, 32'd0, 32'd0, 32'd0, S_RUN));
                1, 2, 3, 4: drive(mk_exp(F_STALL, 32'd0, 32'd0, 32'd0, S_MD));
                5:          drive(mk_exp(F_NONE, 32'd0, 32'd0, 32'd0, S_MD));
                default:    drive(mk_exp(F_NONE, 32'd0, 32'd0, 32'd0, S_RUN));
            endcase
            got = obs(); e = exp_q.pop_front(); n_tests++;
            if (got !== e) begin n_fail++; $display("FAIL muldiv c%0d got=%h exp=%h", c, got, e); end
        end
    endtask

    task automatic test_lsu();
        logic [VW-1:0] got, e;
        for (int c = 0; c < 4; c++) begin
            next_cycle(); set_idle();
            if (c <= 2) begin
                set_load(5'd3); bus.lsu_done_i = (c == 2);
                bus.id_rs1_addr_i = 5'd3; bus.id_rs1_used_i = 1'b1;
            end
            case (c)
                0:       drive(mk_exp(F_STALL, 32'd0, 32'd0, 32'd0, S_RUN));
                1:       drive(mk_exp(F_STALL, 32'd0, 32'd0, 32'd0, S_LSU));
                2:       drive(mk_exp(F_NONE, 32'd0, 32'd0, 32'd0, S_LSU));
                default: drive(mk_exp(F_NONE, 32'd0, 32'd0, 32'd0, S_RUN));
            endcase
            got = obs(); e = exp_q.pop_front(); n_tests++;
            if (got !== e) begin n_fail++; $display("FAIL lsu c%0d got=%h exp=%h", c, got, e); end
        end
    endtask

    task automatic test_jump();
        logic [VW-1:0] got, e;
        for (int c = 0; c < 2; c++) begin
            next_cycle(); set_idle();
            if (c == 0) begin
                bus.ex_jump_flag_i = 1'b1; bus.ex_jump_addr_i = 32'h0000_0100;
                drive(mk_exp(F_JMP, 32'h100, 32'd0, 32'd0, S_RUN));
            end else begin
                bus.ex_jump_addr_i = 32'h0000_0100;
                drive(mk_exp(F_NONE, 32'd0, 32'd0, 32'd0, S_RUN));
            end
            got = obs(); e = exp_q.pop_front(); n_tests++;
            if (got !== e) begin n_fail++; $display("FAIL jump c%0d got=%h exp=%h", c, got, e); end
        end
    endtask

    task automatic test_ecall();
        logic [VW-1:0] got, e;
        for (int c = 0; c < 3; c++) begin
            next_cycle(); set_idle();
            bus.ex_pc_i = 32'h80;
            case (c)
                0: begin bus.ex_ecall_i = 1'b1; drive(mk_exp(F_TRAPW, 32'd0, 32'h80, 32'd11, S_RUN)); end
                1: begin bus.ex_ecall_i = 1'b1; drive(mk_exp(F_JMP, 32'h200, 32'd0, 32'd0, S_TRP)); end
                default: drive(mk_exp(F_NONE, 32'd0, 32'd0, 32'd0, S_RUN));
            endcase
            got = obs(); e = exp_q.pop_front(); n_tests++;
            if (got !== e) begin n_fail++; $display("FAIL ecall c%0d got=%h exp=%h", c, got, e); end
        end
    endtask

    task automatic test_simultaneous();
        logic [VW-1:0] got, e;
        for (int c = 0; c < 6; c++) begin
            next_cycle(); set_idle();
            case (c)
                0, 1: begin
                    bus.ex_ecall_i = 1'b1; bus.ex_ebreak_i = 1'b1; bus.ex_jump_flag_i = 1'b1;
                    bus.ex_jump_addr_i = 32'h400; bus.ex_pc_i = 32'h90;
                    bus.ex_md_sel_i = 1'b1;
                    if (c == 0) drive(mk_exp(F_TRAPW, 32'd0, 32'h90, 32'd11, S_RUN));
                    else        drive(mk_exp(F_JMP, 32'h200, 32'd0, 32'd0, S_TRP));
                end
                3: begin
                    bus.ex_ebreak_i = 1'b1; bus.ex_pc_i = 32'h44; bus.mtvec_i = 32'h1000_0007;
                    drive(mk_exp(F_TRAPW, 32'd0, 32'h44, 32'd3, S_RUN));
                end
                4: begin
                    bus.mtvec_i = 32'h1000_0007;
                    drive(mk_exp(F_JMP, 32'h1000_0004, 32'd0, 32'd0, S_TRP));
                end
                default: drive(mk_exp(F_NONE, 32'd0, 32'd0, 32'd0, S_RUN));
            endcase
            got = obs(); e = exp_q.pop_front(); n_tests++;
            if (got !== e) begin n_fail++; $display("FAIL simultaneous c%0d got=%h exp=%h", c, got, e); end
        end
    endtask

    task automatic test_back_to_back();
        logic [VW-1:0] got, e;
        for (int c = 0; c < 6; c++) begin
            next_cycle(); set_idle();
            bus.ex_jump_addr_i = 32'h300;
            case (c)
                0: begin bus.ex_md_sel_i = 1'b1; drive(mk_exp(F_STALL, 32'd0, 32'd0, 32'd0, S_RUN)); end
                1: begin
                    bus.ex_md_sel_i = 1'b1; bus.ex_jump_flag_i = 1'b1; bus.ex_ecall_i = 1'b1;
                    drive(mk_exp(F_STALL, 32'd0, 32'd0, 32'd0, S_MD));
                end
                2: begin
                    bus.ex_md_sel_i = 1'b1; bus.md_done_i = 1'b1; bus.ex_jump_flag_i = 1'b1;
                    drive(mk_exp(F_NONE, 32'd0, 32'd0, 32'd0, S_MD));
                end
                3: begin bus.ex_jump_flag_i = 1'b1; drive(mk_exp(F_JMP, 32'h300, 32'd0, 32'd0, S_RUN)); end
                4: begin
                    set_load(5'd12); bus.id_rs2_addr_i = 5'd12; bus.id_rs2_used_i = 1'b1;
                    drive(mk_exp(F_LU, 32'd0, 32'd0, 32'd0, S_RUN));
                end
                default: drive(mk_exp(F_NONE, 32'd0, 32'd0, 32'd0, S_RUN));
            endcase
            got = obs(); e = exp_q.pop_front(); n_tests++;
            if (got !== e) begin n_fail++; $display("FAIL back_to_back c%0d got=%h exp=%h", c, got, e); end
        end
    endtask

    task automatic test_reset_mid();
        logic [VW-1:0] got, e;
        for (int c = 0; c < 7; c++) begin
            next_cycle(); set_idle();
            case (c)
                0: begin bus.ex_md_sel_i = 1'b1; drive(mk_exp(F_STALL, 32'd0, 32'd0, 32'd0, S_RUN)); end
                1: begin bus.ex_md_sel_i = 1'b1; drive(mk_exp(F_STALL, 32'd0, 32'd0, 32'd0, S_MD)); end
                2: begin
                    rst = 1'b1; bus.ex_md_sel_i = 1'b1; bus.ex_jump_flag_i = 1'b1;
                    drive(mk_exp(F_NONE, 32'd0, 32'd0, 32'd0, S_MD));
                end
                4: begin
                    bus.ex_ecall_i = 1'b1; bus.ex_pc_i = 32'h20;
                    drive(mk_exp(F_TRAPW, 32'd0, 32'h20, 32'd11, S_RUN));
                end
                5: begin rst = 1'b1; drive(mk_exp(F_NONE, 32'd0, 32'd0, 32'd0, S_TRP)); end
                default: drive(mk_exp(F_NONE, 32'd0, 32'd0, 32'd0, S_RUN));
            endcase
            got = obs(); e = exp_q.pop_front(); n_tests++;
            if (got !== e) begin n_fail++; $display("FAIL reset_mid c%0d got=%h exp=%h", c, got, e); end
            if (c == 2 || c == 5) exp_cnt = '0;
        end
    endtask

    task automatic test_saturation();
        logic [VW-1:0] got, e;
        next_cycle(); set_idle(); bus.ex_md_sel_i = 1'b1;
        drive(mk_exp(F_STALL, 32'd0, 32'd0, 32'd0, S_RUN));
        got = obs(); e = exp_q.pop_front(); n_tests++;
        if (got !== e) begin n_fail++; $display("FAIL sat_issue got=%h exp=%h", got, e); end
        repeat ((1 << CW) + 2) begin
            next_cycle();
            if (exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
            @(negedge clk);
        end
        for (int c = 0; c < 3; c++) begin
            next_cycle(); set_idle();
            case (c)
                0: begin bus.ex_md_sel_i = 1'b1; drive(mk_exp(F_STALL, 32'd0, 32'd0, 32'd0, S_MD)); end
                1: begin
                    bus.ex_md_sel_i = 1'b1; bus.md_done_i = 1'b1;
                    drive(mk_exp(F_NONE, 32'd0, 32'd0, 32'd0, S_MD));
                end
                default: drive(mk_exp(F_NONE, 32'd0, 32'd0, 32'd0, S_RUN));
            endcase
            got = obs(); e = exp_q.pop_front(); n_tests++;
            if (got !== e) begin n_fail++; $display("FAIL saturation c%0d got=%h exp=%h", c, got, e); end
        end
        if (bus.stall_cnt_o !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL sat_value got=%h exp=ffff", bus.stall_cnt_o);
        end
        n_tests++;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_muldiv();
        test_lsu();
        test_jump();
        test_ecall();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
